// File: rtl/neogeo_timing_pkg.sv
// -----------------------------------------------------------------------------
// neogeo_timing_pkg
// Shared Neo Geo video timing constants and the test-pattern selector type.
// Used by the CSYNC generator and its pattern sub-module; the CSYNC decoder
// (neogeo_frontend) is expected to import the same constants.
// No ports (package).
// -----------------------------------------------------------------------------
package neogeo_timing_pkg;

  // Horizontal timing, in pixel clocks (CE cycles).
  localparam int NEO_H_TOTAL     = 384;
  localparam int NEO_H_SYNCLEN   = 29;
  localparam int NEO_H_BACKPORCH = 28;
  localparam int NEO_H_ACTIVE    = 320;

  // Vertical timing, in lines.
  localparam int NEO_V_TOTAL     = 264;
  localparam int NEO_V_SYNCLEN   = 3;
  localparam int NEO_V_BACKPORCH = 21;
  localparam int NEO_V_ACTIVE    = 224;

  // High width of each serration pulse inside a broad (vsync) line.
  localparam int NEO_SERR_LEN    = 29;

  // Widths of the active-position and colour buses.
  localparam int NEO_POS_W = 9;
  localparam int NEO_COL_W = 5;

  localparam logic [NEO_COL_W-1:0] NEO_COL_MAX = 5'd31;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_RAMP  = 2'd3
  } pattern_e;

endpackage

// File: rtl/neogeo_pattern_gen.sv
// -----------------------------------------------------------------------------
// neogeo_pattern_gen
// Purely combinational RGB test-pattern source. The caller registers the
// result and forces it to zero outside active video.
// Ports:
//   i_xpos      active x position (9 bits)
//   i_ypos_lsb  low 4 bits of active y position (only the grid needs y)
//   i_pattern   pattern select (black / bars / grid / ramp)
//   o_r/o_g/o_b 5-bit colour channels
// -----------------------------------------------------------------------------
module neogeo_pattern_gen
  import neogeo_timing_pkg::*;
(
  input  logic [NEO_POS_W-1:0] i_xpos,
  input  logic [3:0]           i_ypos_lsb,
  input  pattern_e             i_pattern,
  output logic [NEO_COL_W-1:0] o_r,
  output logic [NEO_COL_W-1:0] o_g,
  output logic [NEO_COL_W-1:0] o_b
);

  localparam logic [NEO_POS_W-1:0] BAR_WIDTH = NEO_POS_W'(40);

  logic [2:0]           w_bar;
  // Bar colour per channel: index 2 = R, 1 = G, 0 = B.
  logic [NEO_COL_W-1:0] w_bar_col [3];
  logic                 w_grid_on;
  logic [NEO_COL_W-1:0] w_grid_col;
  logic [NEO_COL_W-1:0] w_ramp_col;

  // Eight 40-pixel bars across 320 pixels; bar index only needs 3 bits.
  assign w_bar = 3'(i_xpos / BAR_WIDTH);

  // Each channel is full-on when its bar bit is clear, so bar 0 is white
  // and bar 7 is black.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bar_chan
      assign w_bar_col[gi] = w_bar[gi] ? '0 : NEO_COL_MAX;
    end
  endgenerate

  assign w_grid_on  = (i_xpos[3:0] == 4'd0) || (i_ypos_lsb == 4'd0);
  assign w_grid_col = w_grid_on ? NEO_COL_MAX : '0;
  assign w_ramp_col = i_xpos[8:4];

  always_comb begin
    o_r = '0;
    o_g = '0;
    o_b = '0;
    case (i_pattern)
      PAT_BARS: begin
        o_r = w_bar_col[2];
        o_g = w_bar_col[1];
        o_b = w_bar_col[0];
      end
      PAT_GRID: begin
        o_r = w_grid_col;
        o_g = w_grid_col;
        o_b = w_grid_col;
      end
      PAT_RAMP: begin
        o_r = w_ramp_col;
        o_g = w_ramp_col;
        o_b = w_ramp_col;
      end
      default: begin
        o_r = '0;
        o_g = '0;
        o_b = '0;
      end
    endcase
  end

endmodule

// File: rtl/neogeo_csync_gen.sv
// -----------------------------------------------------------------------------
// neogeo_csync_gen
// Neo Geo video timing generator: composite sync with broad/serration pulses
// on the vsync lines, separate H/V sync, DE, active x/y, a frame-start pulse
// and a selectable RGB test pattern. Everything advances on CE only.
// Ports:
//   VCLK_i        video clock
//   RESET_N_i     asynchronous active-low reset
//   CE_i          pixel clock enable
//   PATTERN_i     pattern select, latched at frame start
//   CSYNC_o       composite sync, active low
//   HSYNC_o       horizontal sync, active low
//   VSYNC_o       vertical sync, active low
//   DE_o          active video
//   R_o/G_o/B_o   pattern colour, zero outside DE
//   xpos/ypos     active position (meaningful while DE)
//   frame_change  high for the CE cycle that outputs h = 0, v = 0
// -----------------------------------------------------------------------------
module neogeo_csync_gen
  import neogeo_timing_pkg::*;
#(
  parameter int H_TOTAL     = NEO_H_TOTAL,
  parameter int H_SYNCLEN   = NEO_H_SYNCLEN,
  parameter int H_BACKPORCH = NEO_H_BACKPORCH,
  parameter int H_ACTIVE    = NEO_H_ACTIVE,
  parameter int V_TOTAL     = NEO_V_TOTAL,
  parameter int V_SYNCLEN   = NEO_V_SYNCLEN,
  parameter int V_BACKPORCH = NEO_V_BACKPORCH,
  parameter int V_ACTIVE    = NEO_V_ACTIVE,
  parameter int SERR_LEN    = NEO_SERR_LEN
) (
  input  logic                 VCLK_i,
  input  logic                 RESET_N_i,
  input  logic                 CE_i,
  input  logic [1:0]           PATTERN_i,
  output logic                 CSYNC_o,
  output logic                 HSYNC_o,
  output logic                 VSYNC_o,
  output logic                 DE_o,
  output logic [NEO_COL_W-1:0] R_o,
  output logic [NEO_COL_W-1:0] G_o,
  output logic [NEO_COL_W-1:0] B_o,
  output logic [NEO_POS_W-1:0] xpos,
  output logic [NEO_POS_W-1:0] ypos,
  output logic                 frame_change
);

  // Counter widths hold the "one past the end" bounds as well.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] C_H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] C_H_SYNC_END  = HW'(H_SYNCLEN);
  localparam logic [HW-1:0] C_X_START     = HW'(H_SYNCLEN + H_BACKPORCH);
  localparam logic [HW-1:0] C_X_END       = HW'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
  localparam logic [HW-1:0] C_H_HALF      = HW'(H_TOTAL / 2);
  localparam logic [HW-1:0] C_SERR1_START = HW'(H_TOTAL / 2 - SERR_LEN);
  localparam logic [HW-1:0] C_SERR2_START = HW'(H_TOTAL - SERR_LEN);

  localparam logic [VW-1:0] C_V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] C_V_SYNC_END  = VW'(V_SYNCLEN);
  localparam logic [VW-1:0] C_Y_START     = VW'(V_SYNCLEN + V_BACKPORCH);
  localparam logic [VW-1:0] C_Y_END       = VW'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
  localparam logic [VW-1:0] C_BROAD_START = VW'(V_TOTAL - V_SYNCLEN);

  // Elaboration-time parameter sanity checks.
  generate
    if (H_SYNCLEN + H_BACKPORCH + H_ACTIVE > H_TOTAL) begin : g_chk_h_active
      $error("neogeo_csync_gen: H_SYNCLEN+H_BACKPORCH+H_ACTIVE exceeds H_TOTAL");
    end
    if (SERR_LEN >= H_TOTAL / 2 - H_SYNCLEN) begin : g_chk_serr
      $error("neogeo_csync_gen: SERR_LEN must be below H_TOTAL/2 - H_SYNCLEN");
    end
    if (V_SYNCLEN < 3) begin : g_chk_vsync
      $error("neogeo_csync_gen: V_SYNCLEN must be at least 3");
    end
    if (V_TOTAL < 17) begin : g_chk_vtotal
      $error("neogeo_csync_gen: V_TOTAL must be at least 17");
    end
  endgenerate

  // Position currently being processed (becomes visible on the outputs
  // at the same CE edge that advances it).
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  pattern_e      r_pattern;

  logic                 r_csync;
  logic                 r_hsync;
  logic                 r_vsync;
  logic                 r_de;
  logic [NEO_COL_W-1:0] r_r;
  logic [NEO_COL_W-1:0] r_g;
  logic [NEO_COL_W-1:0] r_b;
  logic [NEO_POS_W-1:0] r_xpos;
  logic [NEO_POS_W-1:0] r_ypos;
  logic                 r_frame_change;

  logic                 w_h_last;
  logic                 w_v_last;
  logic                 w_frame_start;
  logic                 w_broad;
  logic                 w_serr;
  logic                 w_hsync_n;
  logic                 w_vsync_n;
  logic                 w_csync_n;
  logic                 w_de;
  logic [HW-1:0]        w_x;
  logic [VW-1:0]        w_y;
  logic [NEO_POS_W-1:0] w_xpos;
  logic [NEO_POS_W-1:0] w_ypos;
  logic [NEO_COL_W-1:0] w_pat_r;
  logic [NEO_COL_W-1:0] w_pat_g;
  logic [NEO_COL_W-1:0] w_pat_b;

  assign w_h_last      = (r_h == C_H_LAST);
  assign w_v_last      = (r_v == C_V_LAST);
  assign w_frame_start = (r_h == '0) && (r_v == '0);

  // Broad lines sit at the end of the frame, so the decoder's count of
  // equalisation lines ends exactly as the generator wraps to v = 0.
  assign w_broad   = (r_v >= C_BROAD_START);
  assign w_serr    = ((r_h >= C_SERR1_START) && (r_h < C_H_HALF)) ||
                     (r_h >= C_SERR2_START);
  assign w_hsync_n = (r_h >= C_H_SYNC_END);
  assign w_vsync_n = (r_v >= C_V_SYNC_END);
  assign w_csync_n = w_broad ? w_serr : w_hsync_n;

  assign w_de = (r_h >= C_X_START) && (r_h < C_X_END) &&
                (r_v >= C_Y_START) && (r_v < C_Y_END);

  // Wrapping subtraction, then truncated to the 9-bit position buses.
  assign w_x    = r_h - C_X_START;
  assign w_y    = r_v - C_Y_START;
  assign w_xpos = NEO_POS_W'(w_x);
  assign w_ypos = NEO_POS_W'(w_y);

  neogeo_pattern_gen u_pattern (
    .i_xpos     (w_xpos),
    .i_ypos_lsb (w_ypos[3:0]),
    .i_pattern  (r_pattern),
    .o_r        (w_pat_r),
    .o_g        (w_pat_g),
    .o_b        (w_pat_b)
  );

  always_ff @(posedge VCLK_i or negedge RESET_N_i) begin
    if (!RESET_N_i) begin
      r_h            <= '0;
      r_v            <= '0;
      r_pattern      <= PAT_BLACK;
      r_csync        <= 1'b1;
      r_hsync        <= 1'b1;
      r_vsync        <= 1'b1;
      r_de           <= 1'b0;
      r_r            <= '0;
      r_g            <= '0;
      r_b            <= '0;
      r_xpos         <= '0;
      r_ypos         <= '0;
      r_frame_change <= 1'b0;
    end else if (CE_i) begin
      r_h <= w_h_last ? '0 : r_h + HW'(1);
      if (w_h_last) begin
        r_v <= w_v_last ? '0 : r_v + VW'(1);
      end
      // The pattern only changes at frame start; pixel (0,0) is blanking,
      // so the new pattern is in place before any visible pixel.
      if (w_frame_start) begin
        r_pattern <= pattern_e'(PATTERN_i);
      end
      r_csync        <= w_csync_n;
      r_hsync        <= w_hsync_n;
      r_vsync        <= w_vsync_n;
      r_de           <= w_de;
      r_r            <= w_de ? w_pat_r : '0;
      r_g            <= w_de ? w_pat_g : '0;
      r_b            <= w_de ? w_pat_b : '0;
      r_xpos         <= w_xpos;
      r_ypos         <= w_ypos;
      r_frame_change <= w_frame_start;
    end
  end

  assign CSYNC_o      = r_csync;
  assign HSYNC_o      = r_hsync;
  assign VSYNC_o      = r_vsync;
  assign DE_o         = r_de;
  assign R_o          = r_r;
  assign G_o          = r_g;
  assign B_o          = r_b;
  assign xpos         = r_xpos;
  assign ypos         = r_ypos;
  assign frame_change = r_frame_change;

endmodule

// File: tb/tb_neogeo_csync_gen.sv
`timescale 1ns/1ps
// Directed bench for neogeo_csync_gen. Horizontal timing is the Neo Geo
// default; the frame is shortened to 20 lines (3 sync, 2 back porch,
// 12 active, 3 broad) so whole frames fit in a short run.
module tb_neogeo_csync_gen;

  localparam int HT    = 384;
  localparam int VT    = 20;
  localparam int VS    = 3;
  localparam int VB    = 2;
  localparam int VA    = 12;
  localparam int FRAME = HT * VT;   // 7680 positions per frame

  logic       VCLK_i    = 1'b0;
  logic       RESET_N_i = 1'b0;
  logic       CE_i      = 1'b0;
  logic [1:0] PATTERN_i = 2'd0;
  logic       CSYNC_o, HSYNC_o, VSYNC_o, DE_o, frame_change;
  logic [4:0] R_o, G_o, B_o;
  logic [8:0] xpos, ypos;

  always #5 VCLK_i = ~VCLK_i;

  neogeo_csync_gen #(
    .V_TOTAL     (VT),
    .V_SYNCLEN   (VS),
    .V_BACKPORCH (VB),
    .V_ACTIVE    (VA)
  ) dut (
    .VCLK_i       (VCLK_i),
    .RESET_N_i    (RESET_N_i),
    .CE_i         (CE_i),
    .PATTERN_i    (PATTERN_i),
    .CSYNC_o      (CSYNC_o),
    .HSYNC_o      (HSYNC_o),
    .VSYNC_o      (VSYNC_o),
    .DE_o         (DE_o),
    .R_o          (R_o),
    .G_o          (G_o),
    .B_o          (B_o),
    .xpos         (xpos),
    .ypos         (ypos),
    .frame_change (frame_change)
  );

  int checks = 0;
  int errors = 0;

  // pos = number of positions the DUT has output since reset release.
  int         pos = 0;
  int         vclk_n = 0;
  int         ce_edges = 0;
  logic [1:0] exp_pat = 2'd0;
  int         bad_sync, bad_de, bad_pos, bad_rgb, bad_fc, first_bad;
  int         fall_h0, fall_h192, fall_other, de_cnt;
  logic       prev_cs = 1'b1;
  logic       prev_fc = 1'b0;
  int         fc_vclk_last = 0, fc_vclk_prev = 0;
  int         fc_ce_last = 0, fc_ce_prev = 0;

  function automatic logic [14:0] exp_rgb(input logic [1:0] pat, input int x, input int y);
    logic [4:0] ramp;
    case (pat)
      2'd1: begin
        case (x / 40)
          0: return {5'd31, 5'd31, 5'd31};
          1: return {5'd31, 5'd31, 5'd0};
          2: return {5'd31, 5'd0,  5'd31};
          3: return {5'd31, 5'd0,  5'd0};
          4: return {5'd0,  5'd31, 5'd31};
          5: return {5'd0,  5'd31, 5'd0};
          6: return {5'd0,  5'd0,  5'd31};
          default: return 15'd0;
        endcase
      end
      2'd2: return ((x % 16) == 0 || (y % 16) == 0) ? 15'h7FFF : 15'd0;
      2'd3: begin
        ramp = 5'(x / 16);
        return {ramp, ramp, ramp};
      end
      default: return 15'd0;
    endcase
  endfunction

  task automatic clear_stats();
    bad_sync = 0; bad_de = 0; bad_pos = 0; bad_rgb = 0; bad_fc = 0;
    first_bad = -1;
    fall_h0 = 0; fall_h192 = 0; fall_other = 0; de_cnt = 0;
  endtask

  // One VCLK: drive CE, then profile every output against the position the
  // DUT should be showing; tallies are judged by the scenario tasks.
  task automatic tick(input logic ce);
    int p, h, v, x, y;
    logic e_cs, e_hs, e_vs, e_de, e_fc;
    logic [14:0] e_rgb;
    logic bad;
    CE_i = ce;
    @(posedge VCLK_i);
    if (ce && RESET_N_i) begin
      ce_edges++;
      if (pos % FRAME == 0) exp_pat = PATTERN_i;
      pos++;
    end
    vclk_n++;
    #1;
    bad = 1'b0;
    h = 0; v = 0; x = 0; y = 0;
    if (pos == 0) begin
      e_cs = 1'b1; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fc = 1'b0;
      e_rgb = 15'd0;
      if (xpos !== 9'd0 || ypos !== 9'd0) begin bad_pos++; bad = 1'b1; end
    end else begin
      p = (pos - 1) % FRAME;
      h = p % HT;
      v = p / HT;
      x = h - 57;
      y = v - (VS + VB);
      e_hs = (h >= 29);
      e_vs = (v >= VS);
      e_cs = (v >= VT - VS) ? ((h >= 163 && h <= 191) || h >= 355) : e_hs;
      e_de = (h >= 57) && (h < 377) && (v >= VS + VB) && (v < VS + VB + VA);
      e_fc = (p == 0);
      e_rgb = e_de ? exp_rgb(exp_pat, x, y) : 15'd0;
      if (e_de && (xpos !== 9'(x) || ypos !== 9'(y))) begin bad_pos++; bad = 1'b1; end
    end
    if (CSYNC_o !== e_cs || HSYNC_o !== e_hs || VSYNC_o !== e_vs) begin bad_sync++; bad = 1'b1; end
    if (DE_o !== e_de) begin bad_de++; bad = 1'b1; end
    if (frame_change !== e_fc) begin bad_fc++; bad = 1'b1; end
    if ({R_o, G_o, B_o} !== e_rgb) begin bad_rgb++; bad = 1'b1; end
    if (bad && first_bad < 0) first_bad = pos;
    if (prev_cs === 1'b1 && CSYNC_o === 1'b0) begin
      if (h == 0) fall_h0++;
      else if (h == 192) fall_h192++;
      else fall_other++;
    end
    if (DE_o === 1'b1) de_cnt++;
    if (prev_fc === 1'b0 && frame_change === 1'b1) begin
      fc_vclk_prev = fc_vclk_last; fc_vclk_last = vclk_n;
      fc_ce_prev = fc_ce_last;     fc_ce_last = ce_edges;
    end
    prev_cs = CSYNC_o;
    prev_fc = frame_change;
  endtask

  task automatic test_reset();
    clear_stats();
    RESET_N_i = 1'b0;
    PATTERN_i = 2'd1;
    repeat (3) tick(1'b1);
    checks++; if (CSYNC_o !== 1'b1) begin errors++; $display("FAIL reset_csync: got %b want 1", CSYNC_o); end
    checks++; if (HSYNC_o !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", HSYNC_o); end
    checks++; if (VSYNC_o !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", VSYNC_o); end
    checks++; if (DE_o !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", DE_o); end
    checks++; if ({R_o, G_o, B_o} !== 15'd0) begin errors++; $display("FAIL reset_rgb: got %h want 0", {R_o, G_o, B_o}); end
    checks++; if (xpos !== 9'd0 || ypos !== 9'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", xpos, ypos); end
    checks++; if (frame_change !== 1'b0) begin errors++; $display("FAIL reset_fc: got %b want 0", frame_change); end
    $display("test_reset: outputs held at reset values");
  endtask

  task automatic test_first_frame();
    int p;
    clear_stats();
    RESET_N_i = 1'b1;
    tick(1'b1);
    checks++; if (frame_change !== 1'b1) begin errors++; $display("FAIL first_ce_fc: got %b want 1", frame_change); end
    checks++; if (CSYNC_o !== 1'b0 || HSYNC_o !== 1'b0 || VSYNC_o !== 1'b0)
      begin errors++; $display("FAIL first_ce_sync: got cs=%b hs=%b vs=%b want 0,0,0", CSYNC_o, HSYNC_o, VSYNC_o); end
    for (int i = 1; i < FRAME; i++) begin
      tick(1'b1);
      p = pos - 1;
      if (p == 1976) begin
        checks++; if (DE_o !== 1'b0 || {R_o, G_o, B_o} !== 15'd0)
          begin errors++; $display("FAIL pre_active: got de=%b rgb=%h want 0,0", DE_o, {R_o, G_o, B_o}); end
      end
      if (p == 1977) begin
        checks++; if (DE_o !== 1'b1 || xpos !== 9'd0 || {R_o, G_o, B_o} !== {5'd31, 5'd31, 5'd31})
          begin errors++; $display("FAIL bar_x0: got de=%b x=%0d rgb=%h want 1,0,7fff", DE_o, xpos, {R_o, G_o, B_o}); end
      end
      if (p == 2017) begin
        checks++; if (xpos !== 9'd40 || {R_o, G_o, B_o} !== {5'd31, 5'd31, 5'd0})
          begin errors++; $display("FAIL bar_x40: got x=%0d rgb=%h want 40,7fe0", xpos, {R_o, G_o, B_o}); end
      end
      if (p == 2296) begin
        checks++; if (DE_o !== 1'b1 || xpos !== 9'd319 || {R_o, G_o, B_o} !== 15'd0)
          begin errors++; $display("FAIL bar_x319: got de=%b x=%0d rgb=%h want 1,319,0", DE_o, xpos, {R_o, G_o, B_o}); end
      end
      if (p == 2297) begin
        checks++; if (DE_o !== 1'b0)
          begin errors++; $display("FAIL post_active: got de=%b want 0", DE_o); end
      end
      if (p == 6690) begin
        checks++; if (CSYNC_o !== 1'b0) begin errors++; $display("FAIL broad_h162: got %b want 0", CSYNC_o); end
      end
      if (p == 6691) begin
        checks++; if (CSYNC_o !== 1'b1) begin errors++; $display("FAIL broad_h163: got %b want 1", CSYNC_o); end
      end
      if (p == 6720) begin
        checks++; if (CSYNC_o !== 1'b0) begin errors++; $display("FAIL broad_h192: got %b want 0", CSYNC_o); end
      end
      if (p == 6883) begin
        checks++; if (CSYNC_o !== 1'b1) begin errors++; $display("FAIL broad_h355: got %b want 1", CSYNC_o); end
      end
    end
    checks++; if (fall_h0 !== 20) begin errors++; $display("FAIL csync_falls_h0: got %0d want 20", fall_h0); end
    checks++; if (fall_h192 !== 3) begin errors++; $display("FAIL csync_falls_h192: got %0d want 3", fall_h192); end
    checks++; if (fall_other !== 0) begin errors++; $display("FAIL csync_falls_other: got %0d want 0", fall_other); end
    checks++; if (de_cnt !== 3840) begin errors++; $display("FAIL de_count: got %0d want 3840", de_cnt); end
    checks++; if (bad_sync !== 0) begin errors++; $display("FAIL profile_sync: got %0d bad want 0 (first pos %0d)", bad_sync, first_bad); end
    checks++; if (bad_de !== 0) begin errors++; $display("FAIL profile_de: got %0d bad want 0 (first pos %0d)", bad_de, first_bad); end
    checks++; if (bad_pos !== 0) begin errors++; $display("FAIL profile_xy: got %0d bad want 0 (first pos %0d)", bad_pos, first_bad); end
    checks++; if (bad_rgb !== 0) begin errors++; $display("FAIL profile_rgb: got %0d bad want 0 (first pos %0d)", bad_rgb, first_bad); end
    checks++; if (bad_fc !== 0) begin errors++; $display("FAIL profile_fc: got %0d bad want 0 (first pos %0d)", bad_fc, first_bad); end
    tick(1'b1);
    checks++; if (frame_change !== 1'b1 || fc_vclk_last - fc_vclk_prev !== FRAME)
      begin errors++; $display("FAIL frame_period: got fc=%b period=%0d want 1,%0d", frame_change, fc_vclk_last - fc_vclk_prev, FRAME); end
    $display("test_first_frame: csync falls %0d+%0d, de count %0d", fall_h0, fall_h192, de_cnt);
  endtask

  task automatic test_async_reset();
    repeat (FRAME + 10 * HT + 200 + 1 - pos) tick(1'b1);
    checks++; if (DE_o !== 1'b1 || xpos !== 9'd143 || ypos !== 9'd5)
      begin errors++; $display("FAIL pre_reset_pos: got de=%b x=%0d y=%0d want 1,143,5", DE_o, xpos, ypos); end
    #2;
    RESET_N_i = 1'b0;
    pos = 0;
    #1;
    checks++; if (DE_o !== 1'b0 || {R_o, G_o, B_o} !== 15'd0)
      begin errors++; $display("FAIL async_de_rgb: got de=%b rgb=%h want 0,0", DE_o, {R_o, G_o, B_o}); end
    checks++; if (xpos !== 9'd0 || ypos !== 9'd0)
      begin errors++; $display("FAIL async_xy: got %0d,%0d want 0,0", xpos, ypos); end
    checks++; if (CSYNC_o !== 1'b1 || HSYNC_o !== 1'b1 || VSYNC_o !== 1'b1 || frame_change !== 1'b0)
      begin errors++; $display("FAIL async_sync: got cs=%b hs=%b vs=%b fc=%b want 1,1,1,0", CSYNC_o, HSYNC_o, VSYNC_o, frame_change); end
    clear_stats();
    repeat (2) tick(1'b1);
    checks++; if (bad_sync + bad_de + bad_pos + bad_rgb + bad_fc !== 0)
      begin errors++; $display("FAIL reset_hold: got %0d bad samples want 0", bad_sync + bad_de + bad_pos + bad_rgb + bad_fc); end
    PATTERN_i = 2'd2;
    RESET_N_i = 1'b1;
    $display("test_async_reset: outputs cleared without a clock edge");
  endtask

  task automatic test_ce_toggle();
    clear_stats();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick((i % 2) == 0);
      if (i == 0) begin
        checks++; if (frame_change !== 1'b1) begin errors++; $display("FAIL release_fc: got %b want 1", frame_change); end
      end
      if (i == FRAME) PATTERN_i = 2'd3;
      if (pos - 1 == 4713) begin
        checks++; if ({R_o, G_o, B_o} !== 15'h7FFF)
          begin errors++; $display("FAIL midframe_pattern: got rgb=%h want 7fff", {R_o, G_o, B_o}); end
      end
    end
    tick(1'b1);
    checks++; if (fc_vclk_last - fc_vclk_prev !== 2 * FRAME)
      begin errors++; $display("FAIL ce_frame_vclks: got %0d want %0d", fc_vclk_last - fc_vclk_prev, 2 * FRAME); end
    checks++; if (fc_ce_last - fc_ce_prev !== FRAME)
      begin errors++; $display("FAIL ce_frame_ces: got %0d want %0d", fc_ce_last - fc_ce_prev, FRAME); end
    checks++; if (bad_sync + bad_de + bad_pos !== 0)
      begin errors++; $display("FAIL ce_hold_timing: got %0d bad want 0 (first pos %0d)", bad_sync + bad_de + bad_pos, first_bad); end
    checks++; if (bad_rgb + bad_fc !== 0)
      begin errors++; $display("FAIL ce_hold_rgb_fc: got %0d bad want 0 (first pos %0d)", bad_rgb + bad_fc, first_bad); end
    $display("test_ce_toggle: frame %0d vclks, %0d ces", fc_vclk_last - fc_vclk_prev, fc_ce_last - fc_ce_prev);
  endtask

  task automatic test_pattern_switch();
    clear_stats();
    repeat (FRAME + 5 * HT + 57 + 100 + 1 - pos) tick(1'b1);
    checks++; if (xpos !== 9'd100 || {R_o, G_o, B_o} !== {5'd6, 5'd6, 5'd6})
      begin errors++; $display("FAIL ramp_x100: got x=%0d rgb=%h want 100,18c6", xpos, {R_o, G_o, B_o}); end
    checks++; if (bad_rgb + bad_pos + bad_de !== 0)
      begin errors++; $display("FAIL ramp_profile: got %0d bad want 0 (first pos %0d)", bad_rgb + bad_pos + bad_de, first_bad); end
    $display("test_pattern_switch: ramp active after frame_change");
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_async_reset();
    test_ce_toggle();
    test_pattern_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
